// File: rtl/signed_seq_adder_pkg.sv
// Shared state encoding, BCD digit count and saturation limits
// for signed_seq_adder and its converter.
package signed_seq_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_FIX,
        S_CONV
    } state_t;

    function automatic int bcd_digits(input int w);
        return (w * 301) / 1000 + 1;
    endfunction

    function automatic logic [31:0] sat_smax(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_smin(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] sat_umax(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/signed_seq_adder_bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per cycle.
// done strobes during the final step; bcd holds until the next result.
module bin2bcd_seq
    import signed_seq_adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    sh;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] acc_n;
    logic [CW-1:0]       cnt;

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_n = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
            bcd <= '0;
        end else if (load) begin
            sh  <= bin;
            acc <= '0;
            cnt <= CW'(WIDTH);
        end else if (busy) begin
            sh  <= sh << 1;
            acc <= acc_n;
            cnt <= cnt - CW'(1);
            if (done)
                bcd <= acc_n;
        end
    end

endmodule

// File: rtl/signed_seq_adder.sv
// Sequential carry-iteration adder with sign/magnitude BCD output.
// Define SIGNED_SEQ_ADDER_SAT_EN to clamp the sum on overflow.
module signed_seq_adder
    import signed_seq_adder_pkg::*;
#(
    parameter  int WIDTH  = 4,
    localparam int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    x,
    input  logic [WIDTH-1:0]    y,
    input  logic                mode,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    sum,
    output logic                ovf,
    output logic                neg,
    output logic [4*DIGITS-1:0] bcd
);

`ifdef SIGNED_SEQ_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_smin(WIDTH));
    localparam logic [WIDTH-1:0] UMAX = WIDTH'(sat_umax(WIDTH));
`endif

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] carry;
    logic             x_msb;
    logic             y_msb;
    logic             md;
    logic             cout;
    logic [WIDTH-1:0] fix_sum;
    logic [WIDTH-1:0] mag;
    logic             fix_ovf;
    logic             fix_neg;
    logic [WIDTH-1:0] pend_sum;
    logic             pend_ovf;
    logic             pend_neg;
    logic             load;
    logic             conv_busy;
    logic             conv_done;

    assign carry = a & b;
    assign busy  = (state != S_IDLE) | conv_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        unique case (state)
            S_IDLE: if (start) nxt = S_ADD;
            S_ADD:  if (b == '0) nxt = S_FIX;
            S_FIX: begin
                load = 1'b1;
                nxt  = S_CONV;
            end
            S_CONV: if (conv_done) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Signed overflow: like-signed operands giving an opposite-signed sum.
    always_comb begin
        fix_ovf = md ? ((x_msb == y_msb) && (a[WIDTH-1] != x_msb))
                     : cout;
        fix_sum = a;
`ifdef SIGNED_SEQ_ADDER_SAT_EN
        if (fix_ovf)
            fix_sum = md ? (x_msb ? SMIN : SMAX) : UMAX;
`endif
        fix_neg = md & fix_sum[WIDTH-1];
        mag     = fix_neg ? -fix_sum : fix_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            x_msb    <= 1'b0;
            y_msb    <= 1'b0;
            md       <= 1'b0;
            cout     <= 1'b0;
            pend_sum <= '0;
            pend_ovf <= 1'b0;
            pend_neg <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    a     <= x;
                    b     <= y;
                    x_msb <= x[WIDTH-1];
                    y_msb <= y[WIDTH-1];
                    md    <= mode;
                    cout  <= 1'b0;
                end
                S_ADD: if (b != '0) begin
                    a    <= a ^ b;
                    b    <= carry << 1;
                    cout <= cout | carry[WIDTH-1];
                end
                S_FIX: begin
                    pend_sum <= fix_sum;
                    pend_ovf <= fix_ovf;
                    pend_neg <= fix_neg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            sum  <= '0;
            ovf  <= 1'b0;
            neg  <= 1'b0;
        end else begin
            done <= conv_done;
            if (conv_done) begin
                sum <= pend_sum;
                ovf <= pend_ovf;
                neg <= pend_neg;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_signed_seq_adder.sv
// Self-checking bench for signed_seq_adder (WIDTH=4 and WIDTH=8).
module tb_signed_seq_adder;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  x = '0;
    logic [3:0]  y = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  sum;
    logic        ovf;
    logic        neg;
    logic [7:0]  bcd;

    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic        mode8 = 1'b0;
    logic        start8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        ovf8;
    logic        neg8;
    logic [11:0] bcd8;

    int checks = 0;
    int errors = 0;
    logic [3:0] prev_sum = '0;

    always #5 clk = ~clk;

    signed_seq_adder #(.WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .mode(mode),
        .start(start), .busy(busy), .done(done), .sum(sum),
        .ovf(ovf), .neg(neg), .bcd(bcd)
    );

    signed_seq_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .mode(mode8),
        .start(start8), .busy(busy8), .done(done8), .sum(sum8),
        .ovf(ovf8), .neg(neg8), .bcd(bcd8)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       md;
        logic [3:0] s;
        logic       o;
        logic       ng;
        logic [7:0] b;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input int xv, input int yv,
                                  input bit md, output int s, output bit o,
                                  output bit ng, output int bv, output int n);
        int lim;
        int half;
        int r;
        int sx;
        int sy;
        int mag;
        int aa;
        int bb;
        int cc;
        lim  = 1 << w;
        half = lim / 2;
        r    = xv + yv;
        s    = r % lim;
        o    = (r >= lim);
        if (md) begin
            sx = (xv >= half) ? xv - lim : xv;
            sy = (yv >= half) ? yv - lim : yv;
            r  = sx + sy;
            o  = (r >= half) || (r < -half);
        end
`ifdef SIGNED_SEQ_ADDER_SAT_EN
        if (o)
            s = !md ? lim - 1 : ((r > 0) ? half - 1 : half);
`endif
        ng  = md && (s >= half);
        mag = ng ? lim - s : s;
        bv  = 0;
        for (int i = 0; i < 7; i++) begin
            bv  = bv | ((mag % 10) << (4 * i));
            mag = mag / 10;
        end
        n  = 0;
        aa = xv;
        bb = yv;
        while (bb != 0) begin
            cc = aa & bb;
            aa = aa ^ bb;
            bb = (cc << 1) % lim;
            n++;
        end
    endfunction

    task automatic start_op(input logic [3:0] xv, input logic [3:0] yv,
                            input logic md);
        x     = xv;
        y     = yv;
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] xv,
                            input logic [3:0] yv, input logic md,
                            input logic [3:0] es, input logic eo,
                            input logic eng, input logic [7:0] eb);
        int ms;
        bit mo;
        bit mng;
        int mb;
        int n;
        int lat;
        model(W, int'(xv), int'(yv), md, ms, mo, mng, mb, n);
        start_op(xv, yv, md);
        chk({tag, "_done_low"}, 64'(done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_hold"}, 64'(sum), 64'(prev_sum));
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(n + W + 2));
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        chk({tag, "_neg"}, 64'(neg), 64'(eng));
        chk({tag, "_bcd"}, 64'(bcd), 64'(eb));
        prev_sum = es;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first;
        int pulses;
        int ms;
        bit mo;
        bit mng;
        int mb;
        int n;
        logic [3:0] rx;
        logic [3:0] ry;
        logic       rm;

        tbl[0] = '{4'hD, 4'h2, 1'b1, 4'hF, 1'b0, 1'b1, 8'h01};
        tbl[4] = '{4'h8, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1, 8'h08};
        tbl[5] = '{4'h9, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0, 8'h14};
`ifdef SIGNED_SEQ_ADDER_SAT_EN
        tbl[1] = '{4'h7, 4'h1, 1'b1, 4'h7, 1'b1, 1'b0, 8'h07};
        tbl[2] = '{4'hF, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0, 8'h15};
        tbl[3] = '{4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1, 8'h08};
`else
        tbl[1] = '{4'h7, 4'h1, 1'b1, 4'h8, 1'b1, 1'b1, 8'h08};
        tbl[2] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{4'h8, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00};
`endif

        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_neg", 64'(neg), 64'(0));
        chk("rst_bcd", 64'(bcd), 64'(0));

        // WIDTH=8 zero add, started on the first edge after release.
        @(negedge clk);
        rst_n  = 1'b1;
        x8     = 8'h00;
        y8     = 8'h00;
        mode8  = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk("w8_latency", 64'(lat), 64'(10));
        chk("w8_sum", 64'(sum8), 64'(0));
        chk("w8_bcd", 64'(bcd8), 64'(0));
        chk("w8_ovf", 64'(ovf8), 64'(0));

        for (int i = 0; i < 6; i++)
            check_op($sformatf("vec%0d", i), tbl[i].x, tbl[i].y,
                     tbl[i].md, tbl[i].s, tbl[i].o, tbl[i].ng, tbl[i].b);

        // START while busy and operand changes are ignored.
        start_op(4'h3, 4'h2, 1'b0);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                x     = 4'hF;
                y     = 4'hF;
                mode  = 1'b1;
                start = 1'b1;
            end
            if (k == 3)
                start = 1'b0;
            if (k == 4)
                chk("busy_hold", 64'(sum), 64'(prev_sum));
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    chk("busy_sum", 64'(sum), 64'(5));
                    chk("busy_bcd", 64'(bcd), 64'(8'h05));
                    chk("busy_ovf", 64'(ovf), 64'(0));
                end
            end
        end
        chk("busy_pulses", 64'(pulses), 64'(1));
        chk("busy_latency", 64'(first), 64'(8));
        prev_sum = 4'h5;

        // Reset during conversion aborts without a DONE pulse.
        check_op("pre_rst", 4'h9, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0, 8'h14);
        start_op(4'h3, 4'h2, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("conv_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_bcd", 64'(bcd), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done)
                pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'(0));
        prev_sum = '0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_op("post_rst", 4'hD, 4'h2, 1'b1, 4'hF, 1'b0, 1'b1, 8'h01);

        for (int i = 0; i < 40; i++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            model(W, int'(rx), int'(ry), rm, ms, mo, mng, mb, n);
            check_op($sformatf("rnd%0d", i), rx, ry, rm, 4'(ms), mo, mng,
                     8'(mb));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
